// File: rtl/hex_seq_pkg.sv
// Shared state encoding, digit type and modular step arithmetic for the hex digit sequencer.
// Combinational helpers only; no timing or flow control of their own.
package hex_seq_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'hF;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    typedef struct packed {
        digit_t value;
        logic   wrap;
    } step_t;

    // One modular step; wrap flags only the 15->0 / 0->15 rollover.
    function automatic step_t advance(input digit_t cur, input logic up);
        step_t res;
        res.value = up ? cur + digit_t'(1) : cur - digit_t'(1);
        res.wrap  = up ? (cur == DIGIT_MAX) : (cur == '0);
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer plus stability counter, rise is a registered 1-cycle pulse.
// Raw edge to rise takes 2+DB_CYCLES cycles; no backpressure, level changes only after DB_CYCLES equal samples.
module btn_debounce #(
    parameter int DB_CYCLES = 3
) (
    input  logic clk_2,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            rise   <= 1'b0;
            // Counts consecutive samples disagreeing with the accepted level; any agreeing sample restarts it.
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DB_CYCLES - 1)) begin
                stable_cnt <= '0;
                level      <= sync_b;
                rise       <= sync_b;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hex_digit_sequencer.sv
// Hex digit source for the seven-segment decoder: prescaled auto stepping, debounced manual step, switch load.
// Registered outputs; a press changes digit one cycle after its debounced rise; no backpressure, pulses are fire-and-forget.
module hex_digit_sequencer
    import hex_seq_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int DB_CYCLES = 3
) (
    input  logic               clk_2,
    input  logic               rst_n,
    input  logic               mode_auto,
    input  logic               dir_up,
    input  logic               btn_step,
    input  logic               btn_load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_valid,
    output logic               wrap
);

    localparam int PRE_W = $clog2(TICK_DIV);

    state_t           state;
    logic [PRE_W-1:0] prescaler;
    logic             step_rise;
    logic             load_rise;
    logic             step_level_unused;
    logic             load_level_unused;
    logic             tick;
    step_t            nxt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk_2 (clk_2),
        .rst_n (rst_n),
        .raw   (btn_step),
        .level (step_level_unused),
        .rise  (step_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
        .clk_2 (clk_2),
        .rst_n (rst_n),
        .raw   (btn_load),
        .level (load_level_unused),
        .rise  (load_rise)
    );

    assign tick = (prescaler == PRE_W'(TICK_DIV - 1));
    assign nxt  = advance(digit, dir_up);

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_STOP;
            prescaler   <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            wrap        <= 1'b0;
            // Load wins over any coincident step or tick, which is simply dropped.
            if (load_rise && (state != ST_LOAD)) begin
                state       <= ST_LOAD;
                prescaler   <= '0;
                digit       <= load_val;
                digit_valid <= 1'b1;
            end else begin
                case (state)
                    ST_STOP: begin
                        prescaler <= '0;
                        if (mode_auto) begin
                            state <= ST_RUN;
                        end
                        if (step_rise) begin
                            digit       <= nxt.value;
                            wrap        <= nxt.wrap;
                            digit_valid <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!mode_auto) begin
                            state     <= ST_STOP;
                            prescaler <= '0;
                        end else if (tick) begin
                            prescaler   <= '0;
                            digit       <= nxt.value;
                            wrap        <= nxt.wrap;
                            digit_valid <= 1'b1;
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
                    ST_LOAD: begin
                        // mode_auto is re-read here so a switch flipped during the load is honoured.
                        state     <= mode_auto ? ST_RUN : ST_STOP;
                        prescaler <= '0;
                    end
                    default: begin
                        state     <= ST_STOP;
                        prescaler <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Self-checking bench for hex_digit_sequencer: directed scenarios plus randomized presses and auto runs.
// Expected digits come from plain modular arithmetic on press/tick counts.
module tb_hex_digit_sequencer;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
    // Raw driven between edges: sampled at edge 1, rise after 2+DB_CYCLES edges, digit one edge later.
    localparam int PRESS_LAT = 2 + DB_CYCLES + 1;

    logic       clk_2;
    logic       rst_n;
    logic       mode_auto;
    logic       dir_up;
    logic       btn_step;
    logic       btn_load;
    logic [3:0] load_val;
    logic [3:0] digit;
    logic       digit_valid;
    logic       wrap;

    int         checks;
    int         errors;
    logic [3:0] model_digit;

    hex_digit_sequencer #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk_2       (clk_2),
        .rst_n       (rst_n),
        .mode_auto   (mode_auto),
        .dir_up      (dir_up),
        .btn_step    (btn_step),
        .btn_load    (btn_load),
        .load_val    (load_val),
        .digit       (digit),
        .digit_valid (digit_valid),
        .wrap        (wrap)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic cyc();
        @(posedge clk_2);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        model_digit = 4'h0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode_auto = 1'b0;
        dir_up    = 1'b1;
        btn_step  = 1'b0;
        btn_load  = 1'b0;
        load_val  = 4'h0;
        repeat (3) cyc();
        checks++;
        if (digit !== 4'h0 || digit_valid !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: digit=%h valid=%b wrap=%b, want 0/0/0", digit, digit_valid, wrap);
        end
    endtask

    // Auto count up from reset: RUN entered on edge 1, then one advance every TICK_DIV edges.
    task automatic test_auto_count();
        logic [3:0] exp_d;
        logic       exp_v;
        mode_auto = 1'b1;
        dir_up    = 1'b1;
        rst_n     = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            cyc();
            exp_v = (e > TICK_DIV) && ((e - 1) % TICK_DIV == 0);
            exp_d = 4'((e - 1) / TICK_DIV);
            checks++;
            if (digit !== exp_d || digit_valid !== exp_v || wrap !== (exp_v && exp_d == 4'h0)) begin
                errors++;
                $display("FAIL auto_count e=%0d: digit=%h valid=%b wrap=%b, want %h/%b/%b",
                         e, digit, digit_valid, wrap, exp_d, exp_v, exp_v && exp_d == 4'h0);
            end
        end
        mode_auto = 1'b0;
        cyc();
        model_digit = 4'((70 - 1) / TICK_DIV);
        checks++;
        if (digit !== model_digit || digit_valid !== 1'b0) begin
            errors++;
            $display("FAIL auto_stop: digit=%h valid=%b, want %h/0", digit, digit_valid, model_digit);
        end
    endtask

    task automatic test_manual_wrap_down();
        logic [3:0] exp_d;
        logic       exp_v;
        logic       extra;
        apply_reset();
        mode_auto = 1'b0;
        dir_up    = 1'b0;
        btn_step  = 1'b1;
        for (int e = 1; e <= PRESS_LAT + 8; e++) begin
            cyc();
            exp_v = (e == PRESS_LAT);
            exp_d = (e >= PRESS_LAT) ? 4'hF : 4'h0;
            checks++;
            if (digit !== exp_d || digit_valid !== exp_v || wrap !== exp_v) begin
                errors++;
                $display("FAIL manual_down e=%0d: digit=%h valid=%b wrap=%b, want %h/%b/%b",
                         e, digit, digit_valid, wrap, exp_d, exp_v, exp_v);
            end
        end
        btn_step = 1'b0;
        extra = 1'b0;
        repeat (8) begin
            cyc();
            extra |= digit_valid;
        end
        model_digit = 4'hF;
        checks++;
        if (extra !== 1'b0 || digit !== model_digit) begin
            errors++;
            $display("FAIL manual_release: digit=%h extra_pulse=%b, want F/0", digit, extra);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        btn_step = 1'b1;
        cyc();
        cyc();
        btn_step = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            cyc();
            seen |= digit_valid;
        end
        checks++;
        if (seen !== 1'b0 || digit !== model_digit) begin
            errors++;
            $display("FAIL glitch: digit=%h pulse=%b, want %h/0", digit, seen, model_digit);
        end
    endtask

    task automatic test_load_priority();
        int pulses;
        load_val = 4'hA;
        btn_load = 1'b1;
        btn_step = 1'b1;
        pulses   = 0;
        for (int e = 1; e <= PRESS_LAT + 4; e++) begin
            cyc();
            if (digit_valid === 1'b1) pulses++;
            if (e == PRESS_LAT) begin
                checks++;
                if (digit !== 4'hA || digit_valid !== 1'b1 || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL load_prio_value: digit=%h valid=%b wrap=%b, want A/1/0", digit, digit_valid, wrap);
                end
            end
        end
        btn_load = 1'b0;
        btn_step = 1'b0;
        repeat (8) begin
            cyc();
            if (digit_valid === 1'b1) pulses++;
        end
        model_digit = 4'hA;
        checks++;
        if (pulses != 1 || digit !== model_digit) begin
            errors++;
            $display("FAIL load_prio_single: pulses=%0d digit=%h, want 1/A", pulses, digit);
        end
    endtask

    // Load lands one edge before a tick; the tick is dropped and the next advance follows the LOAD cycle plus TICK_DIV RUN cycles.
    task automatic test_load_before_tick();
        logic [3:0] exp_d;
        logic       exp_v;
        mode_auto = 1'b1;
        dir_up    = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            cyc();
            if (e == 2) begin
                load_val = 4'h3;
                btn_load = 1'b1;
            end
            if (e == 12) btn_load = 1'b0;
            exp_v = (e == 5) || (e == 8) || (e == 13) || (e == 17);
            if (e < 5)       exp_d = model_digit;
            else if (e < 8)  exp_d = model_digit + 4'h1;
            else if (e < 13) exp_d = 4'h3;
            else if (e < 17) exp_d = 4'h4;
            else             exp_d = 4'h5;
            checks++;
            if (digit !== exp_d || digit_valid !== exp_v || wrap !== 1'b0) begin
                errors++;
                $display("FAIL load_tick e=%0d: digit=%h valid=%b wrap=%b, want %h/%b/0",
                         e, digit, digit_valid, wrap, exp_d, exp_v);
            end
        end
        mode_auto = 1'b0;
        cyc();
        model_digit = 4'h5;
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] exp_d;
        logic       exp_v;
        apply_reset();
        mode_auto = 1'b1;
        dir_up    = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            cyc();
            if (e == 28) btn_step = 1'b1;
        end
        checks++;
        if (digit !== 4'h7) begin
            errors++;
            $display("FAIL reset_mid_pre: digit=%h, want 7", digit);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (digit !== 4'h0 || digit_valid !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: digit=%h valid=%b wrap=%b, want 0/0/0", digit, digit_valid, wrap);
        end
        cyc();
        cyc();
        mode_auto = 1'b0;
        rst_n     = 1'b1;
        for (int e = 1; e <= PRESS_LAT + 4; e++) begin
            cyc();
            exp_v = (e == PRESS_LAT);
            exp_d = (e >= PRESS_LAT) ? 4'h1 : 4'h0;
            checks++;
            if (digit !== exp_d || digit_valid !== exp_v || wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_redebounce e=%0d: digit=%h valid=%b wrap=%b, want %h/%b/0",
                         e, digit, digit_valid, wrap, exp_d, exp_v);
            end
        end
        btn_step = 1'b0;
        repeat (8) cyc();
        model_digit = 4'h1;
    endtask

    task automatic test_random_manual();
        logic       do_load;
        logic [3:0] exp_d;
        logic       exp_w;
        logic       seen;
        logic       extra;
        int         lat;
        int         hold;
        for (int i = 0; i < 24; i++) begin
            do_load = ($urandom_range(0, 3) == 0);
            dir_up  = 1'($urandom_range(0, 1));
            // Bounce prefix: short high burst then a short low gap before the stable press.
            if (do_load) btn_load = 1'b1; else btn_step = 1'b1;
            repeat ($urandom_range(1, 2)) cyc();
            btn_load = 1'b0;
            btn_step = 1'b0;
            repeat ($urandom_range(1, 2)) cyc();
            if (do_load) begin
                load_val = 4'($urandom_range(0, 15));
                exp_d    = load_val;
                exp_w    = 1'b0;
                btn_load = 1'b1;
            end else begin
                exp_d    = 4'((int'(model_digit) + (dir_up ? 1 : 15)) % 16);
                exp_w    = dir_up ? (model_digit == 4'hF) : (model_digit == 4'h0);
                btn_step = 1'b1;
            end
            seen = 1'b0;
            lat  = 0;
            for (int e = 1; e <= PRESS_LAT + 3 && !seen; e++) begin
                cyc();
                if (digit_valid === 1'b1) begin
                    seen = 1'b1;
                    lat  = e;
                end
            end
            checks++;
            if (!seen || lat != PRESS_LAT) begin
                errors++;
                $display("FAIL rand_latency i=%0d: seen=%b latency=%0d, want 1/%0d", i, seen, lat, PRESS_LAT);
            end
            checks++;
            if (digit !== exp_d || wrap !== exp_w) begin
                errors++;
                $display("FAIL rand_value i=%0d load=%b: digit=%h wrap=%b, want %h/%b", i, do_load, digit, wrap, exp_d, exp_w);
            end
            model_digit = exp_d;
            extra = 1'b0;
            hold  = $urandom_range(0, 4);
            repeat (hold) begin
                cyc();
                extra |= digit_valid;
            end
            btn_step = 1'b0;
            btn_load = 1'b0;
            repeat (DB_CYCLES + 4) begin
                cyc();
                extra |= digit_valid;
            end
            checks++;
            if (extra !== 1'b0 || digit !== model_digit) begin
                errors++;
                $display("FAIL rand_hold i=%0d: extra_pulse=%b digit=%h, want 0/%h", i, extra, digit, model_digit);
            end
        end
    endtask

    task automatic test_random_auto();
        int         n;
        int         k;
        int         pulses;
        int         wraps;
        int         exp_wraps;
        logic [3:0] exp_d;
        logic       up;
        for (int r = 0; r < 4; r++) begin
            up = 1'($urandom_range(0, 1));
            // Run length avoids a tick on the edge that sees mode_auto drop.
            n  = 4 * $urandom_range(2, 9) + $urandom_range(1, 3);
            k  = (n - 1) / TICK_DIV;
            exp_d     = 4'((int'(model_digit) + (up ? k : 64 - k)) % 16);
            exp_wraps = up ? (int'(model_digit) + k) / 16 : (k + 15 - int'(model_digit)) / 16;
            dir_up    = up;
            mode_auto = 1'b1;
            pulses    = 0;
            wraps     = 0;
            for (int e = 1; e <= n; e++) begin
                cyc();
                if (digit_valid === 1'b1) pulses++;
                if (wrap === 1'b1) wraps++;
            end
            mode_auto = 1'b0;
            cyc();
            checks++;
            if (pulses != k || wraps != exp_wraps) begin
                errors++;
                $display("FAIL rand_auto_counts r=%0d n=%0d: pulses=%0d wraps=%0d, want %0d/%0d", r, n, pulses, wraps, k, exp_wraps);
            end
            checks++;
            if (digit !== exp_d || digit_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_auto_digit r=%0d: digit=%h valid=%b, want %h/0", r, digit, digit_valid, exp_d);
            end
            model_digit = exp_d;
            repeat (3) cyc();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_digit = 4'h0;
        test_reset();
        test_auto_count();
        test_manual_wrap_down();
        test_glitch();
        test_load_priority();
        test_load_before_tick();
        test_reset_mid_run();
        test_random_manual();
        test_random_auto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
